// File: rtl/i2c_write_engine.sv
// Bit-level I2C master write engine: START, three bytes MSB-first with ACK slots, STOP.
// Define I2C_ABORT_ON_NACK_EN to skip the remaining bytes after a NACK.
module i2c_write_engine #(
  parameter int DIV = 1
) (
  input  logic        clk_i2c,
  input  logic        reset_n,
  input  logic [23:0] i2c_data,
  input  logic        go,
  output logic        end_o,
  output logic [2:0]  nack,
  output logic        busy,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

  localparam logic [7:0] PRE_MAX = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [7:0]  pre_q, pre_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] shift_q, shift_d;
  logic [2:0]  nack_q, nack_d;
  logic        end_q, end_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        oe_q, oe_d;
  logic        tick, last, sda_in;

  assign sda_in = i2c_sdat;
  assign tick   = (pre_q == PRE_MAX);
  assign last   = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    nack_d  = nack_q;
    end_d   = end_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (go) begin
        shift_d = i2c_data;
        nack_d  = 3'b000;
        busy_d  = 1'b1;
        state_d = START;
        qtr_d   = 2'd0;
        pre_d   = 8'd0;
      end
      DONE: if (!go) begin
        end_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        pre_d = tick ? 8'd0 : pre_q + 8'd1;
        if (tick) qtr_d = qtr_q + 2'd1;
        case (state_q)
          START: if (last) begin
            state_d = BIT;
            byte_d  = 2'd0;
            bit_d   = 3'd7;
          end
          BIT: if (last) begin
            shift_d = {shift_q[22:0], 1'b0};
            if (bit_q == 3'd0) state_d = ACK;
            else               bit_d   = bit_q - 3'd1;
          end
          ACK: begin
            // slave's ACK is taken at the end of the SCL-high window
            if (tick && qtr_q == 2'd2) nack_d[2'd2 - byte_q] = sda_in;
            if (last) begin
              if (byte_q == 2'd2) state_d = STOP;
`ifdef I2C_ABORT_ON_NACK_EN
              else if (nack_q[2'd2 - byte_q]) begin
                state_d = STOP;
                if (byte_q == 2'd0) nack_d[1:0] = 2'b11;
                else                nack_d[0]   = 1'b1;
              end
`endif
              else begin
                state_d = BIT;
                byte_d  = byte_q + 2'd1;
                bit_d   = 3'd7;
              end
            end
          end
          STOP: if (last) begin
            state_d = DONE;
            end_d   = 1'b1;
            busy_d  = 1'b0;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Pin levels are decoded from the next state so they register together with it.
  always_comb begin
    sclk_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      START: begin sclk_d = (qtr_d != 2'd3); oe_d = qtr_d[1];       end
      BIT:   begin sclk_d = ^qtr_d;          oe_d = !shift_d[23];   end
      ACK:   begin sclk_d = ^qtr_d;          oe_d = 1'b0;           end
      STOP:  begin sclk_d = (qtr_d != 2'd0); oe_d = !qtr_d[1];      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      qtr_q   <= 2'd0;
      pre_q   <= 8'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 24'd0;
      nack_q  <= 3'b000;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      nack_q  <= nack_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      oe_q    <= oe_d;
    end
  end

  assign end_o    = end_q;
  assign nack     = nack_q;
  assign busy     = busy_q;
  assign i2c_sclk = sclk_q;
  assign i2c_sdat = oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: bus monitor + ACKing slave feed a scoreboard of sent words.
module tb_i2c_write_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data0 = '0, data1 = 24'h1A2B3C;
  logic        go0 = 1'b0, go1 = 1'b0;
  logic        end0, end1, busy0, busy1, scl0, scl1;
  logic [2:0]  nack0, nack1;
  logic        drv0 = 1'b0, drv1 = 1'b0;
  logic [2:0]  mask = 3'b000;
  wire         sda0, sda1;
  int          nerr = 0, nchk = 0, cyc = 0, starts = 0;

  pullup (sda0);
  pullup (sda1);
  assign sda0 = drv0 ? 1'b0 : 1'bz;
  assign sda1 = drv1 ? 1'b0 : 1'bz;

  i2c_write_engine #(.DIV(1)) u_dut0 (
    .clk_i2c(clk), .reset_n(rst_n), .i2c_data(data0), .go(go0), .end_o(end0),
    .nack(nack0), .busy(busy0), .i2c_sclk(scl0), .i2c_sdat(sda0));
  i2c_write_engine #(.DIV(4)) u_dut1 (
    .clk_i2c(clk), .reset_n(rst_n), .i2c_data(data1), .go(go1), .end_o(end1),
    .nack(nack1), .busy(busy1), .i2c_sclk(scl1), .i2c_sdat(sda1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] w; int nb; } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bus0 monitor and slave: symbols are counted on SCL falls after START
  logic        prv_scl = 1'b1, prv_sda = 1'b1, in_x = 1'b0, pend = 1'b1;
  logic [23:0] rx = '0;
  int          falls = 0, nsym = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_x = 1'b0; falls = 0; drv0 = 1'b0;
    end else if (prv_scl && scl0 && prv_sda && !sda0) begin
      chk("restart", {31'd0, in_x}, 0);
      in_x = 1'b1; falls = 0; nsym = 0; rx = '0; starts++;
    end else if (in_x && prv_scl && scl0 && !prv_sda && sda0) begin
      in_x = 1'b0;
      chk("sb_pending", {31'd0, sbq.size() > 0}, 1);
      if (sbq.size() > 0) begin
        exp_t e;
        logic [23:0] m;
        e = sbq.pop_front();
        m = 24'((32'd1 << (8 * e.nb)) - 32'd1);
        chk("sb_nsym", nsym, 9 * e.nb);
        chk("sb_data", {8'd0, rx & m}, {8'd0, e.w >> (8 * (3 - e.nb))});
      end
    end else if (in_x && !prv_scl && scl0) begin
      pend = sda0;
    end else if (in_x && prv_scl && !scl0) begin
      if (falls > 0) begin
        if ((falls - 1) % 9 != 8) rx = {rx[22:0], pend};
        nsym++;
      end
      if (falls % 9 == 8 && !mask[2 - falls / 9]) drv0 = 1'b1;
      if (falls > 0 && falls % 9 == 0) drv0 = 1'b0;
      falls++;
    end
    prv_scl = scl0; prv_sda = sda0;
  end

  // bus1 slave: ACKs every byte
  logic p1s = 1'b1, p1d = 1'b1;
  int   f1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      f1 = 0; drv1 = 1'b0;
    end else if (p1s && scl1 && p1d && !sda1) begin
      f1 = 0;
    end else if (p1s && !scl1) begin
      if (f1 % 9 == 8) drv1 = 1'b1;
      if (f1 > 0 && f1 % 9 == 0) drv1 = 1'b0;
      f1++;
    end
    p1s = scl1; p1d = sda1;
  end

  task automatic wait_end(input int lat_e, input bit wave, output int t);
    int k;
    logic [1:0] pe;
    k = 0;
    forever begin
      @(negedge clk);
      if (wave && (k < 4 || (k >= 112 && k < 116))) begin
        case (k)
          0, 1:    pe = 2'b11;
          2, 113:  pe = 2'b10;
          3, 112:  pe = 2'b00;
          default: pe = 2'b11;
        endcase
        chk($sformatf("wave%0d", k), {30'd0, scl0, sda0}, {30'd0, pe});
        chk($sformatf("busy%0d", k), {31'd0, busy0}, 1);
      end
      if (end0 || k >= 3000) break;
      k++;
    end
    chk("latency", k, lat_e);
    chk("busy_done", {31'd0, busy0}, 0);
    t = cyc;
  endtask

  task automatic tail(input int hold);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk("end_hold", {31'd0, end0}, 1);
    go0 = 1'b0;
    @(negedge clk);
    chk("end_fall", {31'd0, end0}, 0);
    @(negedge clk);
  endtask

  task automatic xfer(input logic [23:0] w, input logic [2:0] m, input int nb, input int lat_e,
                      input logic [2:0] nack_e, input int hold, input bit wave, output int t);
    mask = m;
    data0 = w;
    sbq.push_back('{w: w, nb: nb});
    go0 = 1'b1;
    wait_end(lat_e, wave, t);
    chk("nack", {29'd0, nack0}, {29'd0, nack_e});
    tail(hold);
  endtask

  initial begin
    int t, ts[3], cnt, s0, kf1, kr, kf2, k;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, scl0}, 1);
    chk("rst_sda", {31'd0, sda0}, 1);
    chk("rst_end", {31'd0, end0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_nack", {29'd0, nack0}, 0);
    chk("rst_scl1", {31'd0, scl1}, 1);
    rst_n = 1'b1;

    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy0 || !scl0 || !sda0) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    xfer(24'h340E00, 3'b000, 3, 116, 3'b000, 0, 1'b1, t);

`ifdef I2C_ABORT_ON_NACK_EN
    xfer(24'hA55AC3, 3'b010, 2, 80, 3'b011, 0, 1'b0, t);
`else
    xfer(24'hA55AC3, 3'b010, 3, 116, 3'b010, 0, 1'b0, t);
`endif

    xfer(24'h123456, 3'b000, 3, 116, 3'b000, 10, 1'b0, t);
    for (int i = 0; i < 3; i++) xfer(24'($urandom), 3'b000, 3, 116, 3'b000, 0, 1'b0, ts[i]);
    chk("b2b_gap0", ts[1] - ts[0], 119);
    chk("b2b_gap1", ts[2] - ts[1], 119);

    // go pulse and data change mid-transfer
    s0 = starts;
    mask = 3'b000;
    data0 = 24'hC0FFEE;
    sbq.push_back('{w: 24'hC0FFEE, nb: 3});
    go0 = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (j == 1)  data0 = 24'h0F0F0F;
      if (j == 10) go0 = 1'b0;
      if (j == 13) go0 = 1'b1;
    end
    wait_end(102, 1'b0, t);
    chk("one_start", starts - s0, 1);
    tail(0);

    // async reset during byte 1, bit 4
    data0 = 24'h5A0F33;
    go0 = 1'b1;
    repeat (54) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", {31'd0, scl0}, 1);
    chk("mid_rst_sda", {31'd0, sda0}, 1);
    chk("mid_rst_end", {31'd0, end0}, 0);
    chk("mid_rst_busy", {31'd0, busy0}, 0);
    chk("mid_rst_nack", {29'd0, nack0}, 0);
    repeat (3) @(negedge clk);
    sbq.push_back('{w: 24'h5A0F33, nb: 3});
    rst_n = 1'b1;
    wait_end(116, 1'b0, t);
    chk("post_rst_nack", {29'd0, nack0}, 0);
    tail(0);

    // DIV=4 instance
    go1 = 1'b1;
    kf1 = -1; kr = -1; kf2 = -1; k = 0;
    forever begin
      @(negedge clk);
      if (kf1 < 0 && !scl1) kf1 = k;
      else if (kf1 >= 0 && kr < 0 && scl1) kr = k;
      else if (kr >= 0 && kf2 < 0 && !scl1) kf2 = k;
      if (end1 || k >= 3000) break;
      k++;
    end
    chk("div4_latency", k, 464);
    chk("div4_start_fall", kf1, 12);
    chk("div4_bit_rise", kr, 20);
    chk("div4_bit_fall", kf2, 28);
    chk("div4_nack", {29'd0, nack1}, 0);
    go1 = 1'b0;
    @(negedge clk);
    chk("div4_end_fall", {31'd0, end1}, 0);

    repeat (4) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
